// File: rtl/upower_pkg.sv
// upower_pkg: shared definitions for the uPower decode stage.
//   - fmt_e          : format code carried with every decoded entry
//   - OP_* / D/DS    : primary opcodes that select a format
//   - XO_* / X_*     : extended opcodes recognised under primary opcode 31
//   - decoded_entry_t: packed record written into the decode FIFO
//   - is_d_op/is_ds_op/is_x_xo: classification helpers
package upower_pkg;

    typedef enum logic [2:0] {
        FMT_X   = 3'd0,
        FMT_XO  = 3'd1,
        FMT_D   = 3'd2,
        FMT_DS  = 3'd3,
        FMT_B   = 3'd4,
        FMT_I   = 3'd5,
        FMT_ILL = 3'd7
    } fmt_e;

    localparam logic [5:0] OP_XGRP = 6'd31;
    localparam logic [5:0] OP_B    = 6'd19;
    localparam logic [5:0] OP_I    = 6'd18;

    localparam int NUM_D_OPS  = 13;
    localparam int NUM_DS_OPS = 2;
    localparam logic [NUM_D_OPS-1:0][5:0] D_OPCODES = {
        6'd14, 6'd15, 6'd24, 6'd26, 6'd28, 6'd32, 6'd34,
        6'd36, 6'd37, 6'd38, 6'd40, 6'd42, 6'd44
    };
    localparam logic [NUM_DS_OPS-1:0][5:0] DS_OPCODES = {6'd58, 6'd62};

    // XO-form extended opcodes (9 bits, OE bit excluded)
    localparam logic [8:0] XO_ADD  = 9'd266;
    localparam logic [8:0] XO_SUBF = 9'd40;

    // X-form extended opcodes (10 bits)
    localparam logic [9:0] X_AND   = 10'd28;
    localparam logic [9:0] X_NAND  = 10'd476;
    localparam logic [9:0] X_OR    = 10'd444;
    localparam logic [9:0] X_XOR   = 10'd316;
    localparam logic [9:0] X_EXTSW = 10'd986;

    typedef struct packed {
        fmt_e        fmt;
        logic        illegal;
        logic [5:0]  opcode;
        logic [4:0]  rs;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic [4:0]  bo;
        logic [4:0]  bi;
        logic [15:0] si;
        logic [13:0] ds;
        logic [1:0]  xods;
        logic [9:0]  xox;
        logic [8:0]  xoxo;
        logic [23:0] li;
        logic        aa;
        logic        lk;
    } decoded_entry_t;

    function automatic logic is_d_op(input logic [5:0] op);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < NUM_D_OPS; i++) begin
            if (D_OPCODES[i] == op) hit = 1'b1;
        end
        return hit;
    endfunction

    function automatic logic is_ds_op(input logic [5:0] op);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < NUM_DS_OPS; i++) begin
            if (DS_OPCODES[i] == op) hit = 1'b1;
        end
        return hit;
    endfunction

    function automatic logic is_x_xo(input logic [9:0] xo);
        return (xo == X_AND) || (xo == X_NAND) || (xo == X_OR) ||
               (xo == X_XOR) || (xo == X_EXTSW);
    endfunction

endpackage

// File: rtl/upower_field_decode.sv
// upower_field_decode: purely combinational split of a raw 32-bit uPower
// instruction word into a decoded_entry_t.
//   instr : raw instruction word, bit 31 = ISA bit 0
//   entry : opcode, format code, illegal flag and the fields of the detected
//           format; every field that does not belong to that format is 0,
//           because the ALU infers the format from non-zero xoxo/xox/ds.
module upower_field_decode
    import upower_pkg::*;
(
    input  logic [31:0]    instr,
    output decoded_entry_t entry
);

    logic [5:0] op;
    logic [8:0] xo9;
    logic [9:0] xo10;

    assign op   = instr[31:26];
    assign xo9  = instr[9:1];
    assign xo10 = instr[10:1];

    always_comb begin
        entry        = '0;
        entry.opcode = op;
        // XO is tested before X: add/subf share opcode 31 and their
        // instr[10] is the OE bit, so only instr[9:1] identifies them.
        if (op == OP_XGRP && (xo9 == XO_ADD || xo9 == XO_SUBF)) begin
            entry.fmt  = FMT_XO;
            entry.rs   = instr[25:21];
            entry.ra   = instr[20:16];
            entry.rb   = instr[15:11];
            entry.xoxo = xo9;
        end else if (op == OP_XGRP && is_x_xo(xo10)) begin
            entry.fmt = FMT_X;
            entry.rs  = instr[25:21];
            entry.ra  = instr[20:16];
            entry.rb  = instr[15:11];
            entry.xox = xo10;
        end else if (is_d_op(op)) begin
            entry.fmt = FMT_D;
            entry.rs  = instr[25:21];
            entry.ra  = instr[20:16];
            entry.si  = instr[15:0];
        end else if (is_ds_op(op)) begin
            entry.fmt  = FMT_DS;
            entry.rs   = instr[25:21];
            entry.ra   = instr[20:16];
            entry.ds   = instr[15:2];
            entry.xods = instr[1:0];
        end else if (op == OP_B) begin
            // rs/ra also carry BO/BI so consumers reading the generic
            // register fields see the condition operands.
            entry.fmt = FMT_B;
            entry.rs  = instr[25:21];
            entry.ra  = instr[20:16];
            entry.bo  = instr[25:21];
            entry.bi  = instr[20:16];
            entry.aa  = instr[1];
            entry.lk  = instr[0];
        end else if (op == OP_I) begin
            entry.fmt = FMT_I;
            entry.li  = instr[25:2];
            entry.aa  = instr[1];
            entry.lk  = instr[0];
        end else begin
            // opcode 31 with an unknown extended opcode also lands here
            entry.fmt     = FMT_ILL;
            entry.illegal = 1'b1;
        end
    end

endmodule

// File: rtl/upower_decode_stage.sv
// upower_decode_stage: instruction decode stage of the 64-bit uPower
// datapath. Raw words arrive on a valid/ready input, are decoded
// combinationally, and the decoded record is buffered in a small FIFO whose
// head drives the output fields.
//   clk, rst_n         : clock (rising edge), async active-low reset
//   flush              : synchronous FIFO clear, drops same-cycle push/pop
//   in_valid/in_ready  : input handshake; in_ready is a register
//   in_instr           : raw instruction word
//   out_valid/out_ready: output handshake on the FIFO head
//   opcode..lk, fmt, illegal : decoded head entry, all 0 while empty
//   decoded_cnt/illegal_cnt  : saturating counts of accepted words
module upower_decode_stage
    import upower_pkg::*;
#(
    parameter int FIFO_DEPTH = 2,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [5:0]       opcode,
    output logic [4:0]       rs,
    output logic [4:0]       ra,
    output logic [4:0]       rb,
    output logic [4:0]       bo,
    output logic [4:0]       bi,
    output logic [15:0]      si,
    output logic [13:0]      ds,
    output logic [1:0]       xods,
    output logic [9:0]       xox,
    output logic [8:0]       xoxo,
    output logic [23:0]      li,
    output logic             aa,
    output logic             lk,
    output logic [2:0]       fmt,
    output logic             illegal,
    output logic [CNT_W-1:0] decoded_cnt,
    output logic [CNT_W-1:0] illegal_cnt
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(FIFO_DEPTH);

    decoded_entry_t dec_entry;
    decoded_entry_t head_entry;
    decoded_entry_t mem_reg [FIFO_DEPTH];

    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [PTR_W:0]   count_reg, count_next;
    logic             in_ready_reg, in_ready_next;
    logic             push, pop;

    upower_field_decode u_field_decode (
        .instr (in_instr),
        .entry (dec_entry)
    );

    assign in_ready  = in_ready_reg;
    assign out_valid = (count_reg != '0);
    assign push      = in_valid & in_ready_reg;
    assign pop       = out_valid & out_ready;

    always_comb begin
        wr_ptr_next   = wr_ptr_reg;
        rd_ptr_next   = rd_ptr_reg;
        count_next    = count_reg;
        if (flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (push) wr_ptr_next = wr_ptr_reg + PTR_W'(1);
            if (pop)  rd_ptr_next = rd_ptr_reg + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_next = count_reg + (PTR_W + 1)'(1);
                2'b01:   count_next = count_reg - (PTR_W + 1)'(1);
                default: count_next = count_reg;
            endcase
        end
        // in_ready is registered from the next count, so out_ready never
        // reaches in_ready combinationally.
        in_ready_next = (count_next < DEPTH_C);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            in_ready_reg <= 1'b1;
        end else begin
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            count_reg    <= count_next;
            in_ready_reg <= in_ready_next;
        end
    end

    // Storage carries no reset: an entry is only observable through
    // count_reg, which is reset.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem_reg[wr_ptr_reg] <= dec_entry;
        end
    end

    assign head_entry = out_valid ? mem_reg[rd_ptr_reg] : '0;

    assign opcode  = head_entry.opcode;
    assign rs      = head_entry.rs;
    assign ra      = head_entry.ra;
    assign rb      = head_entry.rb;
    assign bo      = head_entry.bo;
    assign bi      = head_entry.bi;
    assign si      = head_entry.si;
    assign ds      = head_entry.ds;
    assign xods    = head_entry.xods;
    assign xox     = head_entry.xox;
    assign xoxo    = head_entry.xoxo;
    assign li      = head_entry.li;
    assign aa      = head_entry.aa;
    assign lk      = head_entry.lk;
    assign fmt     = head_entry.fmt;
    assign illegal = head_entry.illegal;

    // Counter 0 counts every accepted word, counter 1 only illegal ones.
    // Both count on accept even if a flush drops the word.
    logic [1:0]       cnt_inc;
    logic [CNT_W-1:0] cnt_reg [2];

    assign cnt_inc[0] = push;
    assign cnt_inc[1] = push & dec_entry.illegal;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_reg[gi] <= '0;
                end else if (cnt_inc[gi] && (cnt_reg[gi] != '1)) begin
                    cnt_reg[gi] <= cnt_reg[gi] + CNT_W'(1);
                end
            end
        end
    endgenerate

    assign decoded_cnt = cnt_reg[0];
    assign illegal_cnt = cnt_reg[1];

endmodule

// File: tb/tb_upower_decode_stage.sv
module tb_upower_decode_stage;

    localparam int DEPTH    = 2;
    localparam int TB_CNT_W = 4;
    localparam int CNT_MAX  = (1 << TB_CNT_W) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;
    logic [31:0] in_instr = '0;
    logic in_ready, out_valid, aa, lk, illegal;
    logic [5:0] opcode;
    logic [4:0] rs, ra, rb, bo, bi;
    logic [15:0] si;
    logic [13:0] ds;
    logic [1:0] xods;
    logic [9:0] xox;
    logic [8:0] xoxo;
    logic [23:0] li;
    logic [2:0] fmt;
    logic [TB_CNT_W-1:0] decoded_cnt, illegal_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    upower_decode_stage #(.FIFO_DEPTH(DEPTH), .CNT_W(TB_CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .out_valid(out_valid), .out_ready(out_ready),
        .opcode(opcode), .rs(rs), .ra(ra), .rb(rb), .bo(bo), .bi(bi),
        .si(si), .ds(ds), .xods(xods), .xox(xox), .xoxo(xoxo), .li(li),
        .aa(aa), .lk(lk), .fmt(fmt), .illegal(illegal),
        .decoded_cnt(decoded_cnt), .illegal_cnt(illegal_cnt)
    );

    // ---------------- behavioural model ----------------
    typedef struct {
        int opcode, rs, ra, rb, bo, bi, si, ds, xods, xox, xoxo, li, aa, lk, fmt, ill;
    } exp_t;

    function automatic int bits(input logic [31:0] w, input int lo, input int n);
        return int'((w >> lo) & ((32'd1 << n) - 32'd1));
    endfunction

    function automatic exp_t mdl(input logic [31:0] w);
        exp_t e;
        int op, x9, x10;
        e = '{default: 0};
        op  = bits(w, 26, 6);
        x9  = bits(w, 1, 9);
        x10 = bits(w, 1, 10);
        e.opcode = op;
        if (op == 31 && (x9 == 266 || x9 == 40)) begin
            e.fmt = 1; e.rs = bits(w, 21, 5); e.ra = bits(w, 16, 5);
            e.rb = bits(w, 11, 5); e.xoxo = x9;
        end else if (op == 31 && (x10 inside {28, 476, 444, 316, 986})) begin
            e.fmt = 0; e.rs = bits(w, 21, 5); e.ra = bits(w, 16, 5);
            e.rb = bits(w, 11, 5); e.xox = x10;
        end else if (op inside {14, 15, 24, 26, 28, 32, 34, 36, 37, 38, 40, 42, 44}) begin
            e.fmt = 2; e.rs = bits(w, 21, 5); e.ra = bits(w, 16, 5); e.si = bits(w, 0, 16);
        end else if (op == 58 || op == 62) begin
            e.fmt = 3; e.rs = bits(w, 21, 5); e.ra = bits(w, 16, 5);
            e.ds = bits(w, 2, 14); e.xods = bits(w, 0, 2);
        end else if (op == 19) begin
            e.fmt = 4; e.rs = bits(w, 21, 5); e.ra = bits(w, 16, 5);
            e.bo = e.rs; e.bi = e.ra; e.aa = bits(w, 1, 1); e.lk = bits(w, 0, 1);
        end else if (op == 18) begin
            e.fmt = 5; e.li = bits(w, 2, 24); e.aa = bits(w, 1, 1); e.lk = bits(w, 0, 1);
        end else begin
            e.fmt = 7; e.ill = 1;
        end
        return e;
    endfunction

    exp_t q[$];
    int m_dec = 0;
    int m_ill = 0;

    always @(posedge clk or negedge rst_n) begin
        bit m_push, m_pop;
        exp_t e;
        if (!rst_n) begin
            q.delete();
            m_dec = 0;
            m_ill = 0;
        end else begin
            m_push = in_valid && (q.size() < DEPTH);
            m_pop  = out_ready && (q.size() > 0);
            e = mdl(in_instr);
            if (m_push) begin
                if (m_dec < CNT_MAX) m_dec++;
                if (e.ill != 0 && m_ill < CNT_MAX) m_ill++;
            end
            if (flush) begin
                q.delete();
            end else begin
                if (m_pop) void'(q.pop_front());
                if (m_push) q.push_back(e);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at t=%0t: got %0d, expected %0d", nm, $time, act, exp);
        end
    endtask

    // compare process: every cycle, away from the active edge
    always @(negedge clk) begin
        exp_t h;
        h = '{default: 0};
        if (q.size() > 0) h = q[0];
        chk("out_valid", out_valid, (q.size() > 0));
        chk("in_ready", in_ready, (q.size() < DEPTH));
        chk("opcode", opcode, h.opcode);
        chk("rs", rs, h.rs);
        chk("ra", ra, h.ra);
        chk("rb", rb, h.rb);
        chk("bo", bo, h.bo);
        chk("bi", bi, h.bi);
        chk("si", si, h.si);
        chk("ds", ds, h.ds);
        chk("xods", xods, h.xods);
        chk("xox", xox, h.xox);
        chk("xoxo", xoxo, h.xoxo);
        chk("li", li, h.li);
        chk("aa", aa, h.aa);
        chk("lk", lk, h.lk);
        chk("fmt", fmt, h.fmt);
        chk("illegal", illegal, h.ill);
        chk("decoded_cnt", decoded_cnt, m_dec);
        chk("illegal_cnt", illegal_cnt, m_ill);
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic push1(input logic [31:0] w);
        in_valid = 1'b1;
        in_instr = w;
        cyc();
        in_valid = 1'b0;
        $display("push %08h -> fmt=%0d illegal=%0d out_valid=%0d", w, fmt, illegal, out_valid);
    endtask

    initial begin
        logic [31:0] w;
        cyc();
        chk("rst out_valid", out_valid, 0);
        chk("rst in_ready", in_ready, 1);
        chk("rst fmt", fmt, 0);
        chk("rst decoded_cnt", decoded_cnt, 0);
        rst_n = 1'b1;
        cyc();

        // decode vectors, streaming with out_ready=1
        out_ready = 1'b1;
        push1(32'h7C642A14);
        chk("xo fmt", fmt, 1);    chk("xo xoxo", xoxo, 266);
        chk("xo rs", rs, 3);      chk("xo ra", ra, 4);
        chk("xo rb", rb, 5);      chk("xo xox", xox, 0);
        chk("xo si", si, 0);      chk("xo ds", ds, 0);
        chk("xo cnt", decoded_cnt, 1);
        push1(32'h7C642838);
        chk("x fmt", fmt, 0);     chk("x xox", xox, 28);
        chk("x xoxo", xoxo, 0);   chk("x rb", rb, 5);
        push1(32'h3864000A);
        chk("d fmt", fmt, 2);     chk("d si", si, 10);
        chk("d rs", rs, 3);       chk("d rb", rb, 0);
        push1(32'hE8640008);
        chk("ds fmt", fmt, 3);    chk("ds ds", ds, 2);
        chk("ds si", si, 0);
        push1(32'h00000000);
        chk("ill0 illegal", illegal, 1);
        chk("ill0 fmt", fmt, 7);
        chk("ill0 cnt", illegal_cnt, 1);
        push1(32'h7C0003FE);
        chk("ill31 illegal", illegal, 1);
        chk("ill31 opcode", opcode, 31);
        chk("ill31 cnt", illegal_cnt, 2);
        push1(32'h4D820013);
        chk("b bo", bo, 12);      chk("b lk", lk, 1);
        push1(32'h48000101);
        chk("i li", li, 32'h40);  chk("i si", si, 0);
        push1(32'h7C0007B4);
        chk("x986 xox", xox, 986);
        push1(32'h7C000450);
        chk("xo40 xoxo", xoxo, 40);
        cyc();

        // backpressure: A, B, C back to back with out_ready=0
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_instr = 32'h3864000A; cyc();
        in_instr = 32'h7C642838; cyc();
        chk("bp in_ready", in_ready, 0);
        in_instr = 32'h4D820013; cyc();
        chk("bp head fmt", fmt, 2);
        chk("bp head si", si, 10);
        cyc();
        chk("bp stable si", si, 10);
        out_ready = 1'b1;
        cyc();
        chk("bp B fmt", fmt, 0);
        chk("bp B xox", xox, 28);
        cyc();
        chk("bp C fmt", fmt, 4);
        chk("bp C bo", bo, 12);
        in_valid = 1'b0;
        cyc();
        chk("bp drained", out_valid, 0);

        // flush with a full FIFO and a word presented
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_instr = 32'h48000101; cyc();
        in_instr = 32'h7C0007B4; cyc();
        chk("fl full", in_ready, 0);
        in_instr = 32'h3864000A;
        flush = 1'b1;
        cyc();
        chk("fl out_valid", out_valid, 0);
        chk("fl fmt", fmt, 0);
        flush = 1'b0;
        in_valid = 1'b0;
        cyc();
        chk("fl dropped", out_valid, 0);

        // asynchronous reset mid-stream
        push1(32'h7C000450);
        chk("ar before", out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar out_valid", out_valid, 0);
        chk("ar xoxo", xoxo, 0);
        chk("ar decoded_cnt", decoded_cnt, 0);
        chk("ar in_ready", in_ready, 1);
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();

        // counter saturation with illegal words
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            w = i * 32'd12345;
            w[31:26] = (i % 2 == 1) ? 6'd63 : 6'd0;
            push1(w);
        end
        cyc();
        chk("sat decoded_cnt", decoded_cnt, CNT_MAX);
        chk("sat illegal_cnt", illegal_cnt, CNT_MAX);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
